// File: rtl/out_port_wrr_sched_if.sv
// out_port_wrr_sched_if
//   Bundle between the input-port FIFO read sides / output driver and the
//   weighted round-robin scheduler of one output port.
//   Ports (signals):
//     req, last    : per-requester head-of-line beat valid and end-of-packet
//     out_ready    : output driver accepts a beat this cycle
//     cfg_we/idx/weight : weight register write port
//     gnt, gnt_idx : one-hot grant and its index
//     beat_xfer    : a beat moves this cycle
//     pkt_done     : pulse after a last-beat transfer
//     err_timeout  : pulse on forced release of a stalled lock
//   Modports: master = requesters/driver/config side, slave = scheduler.
interface out_port_wrr_sched_if #(
  parameter int N_REQ    = 4,
  parameter int WEIGHT_W = 4
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    last;
  logic                out_ready;
  logic                cfg_we;
  logic [IDX_W-1:0]    cfg_idx;
  logic [WEIGHT_W-1:0] cfg_weight;

  logic [N_REQ-1:0]    gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                beat_xfer;
  logic                pkt_done;
  logic                err_timeout;

  modport master (
    output req, last, out_ready, cfg_we, cfg_idx, cfg_weight,
    input  gnt, gnt_idx, beat_xfer, pkt_done, err_timeout
  );

  modport slave (
    input  req, last, out_ready, cfg_we, cfg_idx, cfg_weight,
    output gnt, gnt_idx, beat_xfer, pkt_done, err_timeout
  );
endinterface

// File: rtl/out_port_wrr_sched.sv
// out_port_wrr_sched
//   Weighted round-robin, packet-granular scheduler for one output port.
//   A grant locks the output to one requester until it transfers a last
//   beat, or until TIMEOUT_CYC locked cycles pass without any transfer.
//   Each requester gets up to weight[i] consecutive packets per turn.
//   Ports:
//     clk         : clock, rising edge
//     rst         : synchronous active-high reset (also resets weights)
//     bus (slave) : req/last/out_ready/cfg_* in, gnt/gnt_idx/beat_xfer/
//                   pkt_done/err_timeout out
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | gnt=0; pick the next requester when any is eligible
//   LOCK  | gnt held on one requester until last beat or timeout
module out_port_wrr_sched #(
  parameter int N_REQ       = 4,
  parameter int WEIGHT_W    = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                 clk,
  input logic                 rst,
  out_port_wrr_sched_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [IDX_W-1:0]    PTR_RST  = IDX_W'(N_REQ - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [N_REQ-1:0]    ONE_HOT0 = N_REQ'(1);
  localparam logic [WEIGHT_W-1:0] W_ONE    = WEIGHT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t              state;
  logic [WEIGHT_W-1:0] weight [N_REQ];
  logic [WEIGHT_W-1:0] credit;
  logic [IDX_W-1:0]    ptr;
  logic [TMO_W-1:0]    tmo_cnt;

  logic [N_REQ-1:0]    gnt_q;
  logic [IDX_W-1:0]    gnt_idx_q;
  logic                pkt_done_q;
  logic                err_timeout_q;

  logic [N_REQ-1:0]    elig;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    pick_idx;
  logic                any_elig;
  logic                keep_ptr;
  logic [IDX_W-1:0]    sel_idx;
  logic                xfer;
  logic                xfer_last;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = bus.req[i] && (weight[i] != '0);
    end
  end

  // Walk the ring from the farthest candidate (ptr itself) to the nearest
  // (ptr+1); the last hit is therefore the first eligible after ptr.
  always_comb begin
    pick_idx = ptr;
    any_elig = 1'b0;
    cand     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (elig[cand]) begin
        pick_idx = cand;
        any_elig = 1'b1;
      end
    end
  end

  // Remaining credit lets the current pointer win again without searching.
  assign keep_ptr = elig[ptr] && (credit != '0);
  assign sel_idx  = keep_ptr ? ptr : pick_idx;

  // gnt is nonzero only in LOCK, so this is the locked requester's beat.
  assign xfer      = (|(gnt_q & bus.req)) && bus.out_ready;
  assign xfer_last = xfer && bus.last[gnt_idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= PTR_RST;
      credit        <= '0;
      tmo_cnt       <= '0;
      gnt_q         <= '0;
      gnt_idx_q     <= '0;
      pkt_done_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        weight[i] <= W_ONE;
      end
    end else begin
      pkt_done_q    <= 1'b0;
      err_timeout_q <= 1'b0;

      // A new weight is visible from the next cycle; a selection in this
      // cycle still reads the old value.
      if (bus.cfg_we && (int'(bus.cfg_idx) < N_REQ)) begin
        weight[bus.cfg_idx] <= bus.cfg_weight;
      end

      case (state)
        IDLE: begin
          if (any_elig) begin
            if (keep_ptr) begin
              credit <= credit - W_ONE;
            end else begin
              ptr    <= pick_idx;
              credit <= weight[pick_idx] - W_ONE;
            end
            gnt_q     <= ONE_HOT0 << sel_idx;
            gnt_idx_q <= sel_idx;
            tmo_cnt   <= '0;
            state     <= LOCK;
          end
        end

        LOCK: begin
          if (xfer) begin
            tmo_cnt <= '0;
            if (xfer_last) begin
              gnt_q      <= '0;
              pkt_done_q <= 1'b1;
              state      <= IDLE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // Forced release: drop any remaining credit, keep ptr on the
            // stalled requester so the next search starts just after it.
            gnt_q         <= '0;
            err_timeout_q <= 1'b1;
            credit        <= '0;
            tmo_cnt       <= '0;
            state         <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        default: begin
          gnt_q <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_idx     = gnt_idx_q;
  assign bus.beat_xfer   = xfer;
  assign bus.pkt_done    = pkt_done_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_out_port_wrr_sched.sv
// tb_out_port_wrr_sched
//   Directed bench for out_port_wrr_sched (N_REQ=4, WEIGHT_W=4,
//   TIMEOUT_CYC=8). Expected grant indices are queued as stimulus is
//   applied and popped whenever the DUT raises a new grant.
module tb_out_port_wrr_sched;

  logic clk;
  logic rst;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_q[$];
  logic [3:0] prev_gnt = 4'b0;
  int beats;

  out_port_wrr_sched_if #(.N_REQ(4), .WEIGHT_W(4)) bus ();

  out_port_wrr_sched #(
    .N_REQ(4),
    .WEIGHT_W(4),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock, then check any newly raised grant against the queue.
  task automatic cyc();
    int e;
    @(posedge clk);
    #1;
    if (bus.gnt !== 4'b0 && prev_gnt === 4'b0) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("gnt_idx", 32'(bus.gnt_idx), 32'(e));
        chk("gnt_onehot", 32'(bus.gnt), 32'(1) << e);
      end
    end
    prev_gnt = bus.gnt;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.req        = 4'b0;
    bus.last       = 4'b0;
    bus.out_ready  = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_idx    = 2'd0;
    bus.cfg_weight = 4'd0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- reset values ----------------
    do_reset();
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_gnt_idx", 32'(bus.gnt_idx), 32'h0);
    chk("rst_pkt_done", 32'(bus.pkt_done), 32'h0);
    chk("rst_err_timeout", 32'(bus.err_timeout), 32'h0);

    // ---------------- basic round-robin ----------------
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    bus.req = 4'b1111; bus.last = 4'b1111; bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_gnt_on", 32'(bus.gnt != 4'b0), 32'h1);
      chk("rr_xfer", 32'(bus.beat_xfer), 32'h1);
      cyc();
      chk("rr_gap_gnt", 32'(bus.gnt), 32'h0);
      chk("rr_pkt_done", 32'(bus.pkt_done), 32'h1);
      chk("rr_no_err", 32'(bus.err_timeout), 32'h0);
    end
    bus.req = 4'b0;
    cyc();
    chk("rr_drain", 32'(exp_q.size()), 32'h0);

    // ---------------- weighting {3,1,1,1} ----------------
    do_reset();
    bus.cfg_we = 1'b1; bus.cfg_idx = 2'd0; bus.cfg_weight = 4'd3;
    cyc();
    bus.cfg_we = 1'b0;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    bus.req = 4'b1111; bus.last = 4'b1111; bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("wt_gnt_on", 32'(bus.gnt != 4'b0), 32'h1);
      cyc();
      chk("wt_pkt_done", 32'(bus.pkt_done), 32'h1);
    end
    bus.req = 4'b0;
    cyc();
    chk("wt_drain", 32'(exp_q.size()), 32'h0);

    // ---------------- multi-beat lock ----------------
    do_reset();
    exp_q.push_back(1); exp_q.push_back(2);
    bus.req = 4'b0110; bus.last = 4'b0; bus.out_ready = 1'b0;
    cyc();
    beats = 0;
    for (int c = 0; c < 20 && beats < 5; c++) begin
      bus.out_ready = ((c % 2) == 0);
      bus.last = (beats == 4 && bus.out_ready) ? 4'b0010 : 4'b0000;
      #1;
      chk("ml_hold", 32'(bus.gnt), 32'h2);
      chk("ml_xfer", 32'(bus.beat_xfer), 32'(bus.out_ready));
      if (bus.out_ready) beats++;
      cyc();
    end
    bus.last = 4'b0;
    chk("ml_release", 32'(bus.gnt), 32'h0);
    chk("ml_pkt_done", 32'(bus.pkt_done), 32'h1);
    cyc();
    chk("ml_next_gnt", 32'(bus.gnt), 32'h4);
    chk("ml_done_pulse", 32'(bus.pkt_done), 32'h0);
    chk("ml_drain", 32'(exp_q.size()), 32'h0);

    // ---------------- disable while locked ----------------
    do_reset();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(3);
    bus.req = 4'b1111; bus.last = 4'b1111; bus.out_ready = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    bus.last = 4'b1011;
    cyc();
    chk("dis_gnt2", 32'(bus.gnt), 32'h4);
    bus.cfg_we = 1'b1; bus.cfg_idx = 2'd2; bus.cfg_weight = 4'd0;
    cyc();
    chk("dis_hold", 32'(bus.gnt), 32'h4);
    chk("dis_no_done", 32'(bus.pkt_done), 32'h0);
    bus.cfg_we = 1'b0; bus.last = 4'b1111;
    cyc();
    chk("dis_complete", 32'(bus.pkt_done), 32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("dis_gnt_on", 32'(bus.gnt != 4'b0), 32'h1);
      cyc();
      chk("dis_pkt_done", 32'(bus.pkt_done), 32'h1);
    end
    bus.req = 4'b0;
    cyc();
    chk("dis_drain", 32'(exp_q.size()), 32'h0);

    // ---------------- timeout ----------------
    do_reset();
    exp_q.push_back(3); exp_q.push_back(0);
    bus.req = 4'b1000; bus.last = 4'b0; bus.out_ready = 1'b1;
    cyc();
    chk("to_first_xfer", 32'(bus.beat_xfer), 32'h1);
    cyc();
    bus.req = 4'b0001;
    for (int i = 2; i <= 9; i++) begin
      chk("to_hold", 32'(bus.gnt), 32'h8);
      chk("to_err_low", 32'(bus.err_timeout), 32'h0);
      cyc();
    end
    chk("to_err_pulse", 32'(bus.err_timeout), 32'h1);
    chk("to_released", 32'(bus.gnt), 32'h0);
    chk("to_no_done", 32'(bus.pkt_done), 32'h0);
    cyc();
    chk("to_next_gnt", 32'(bus.gnt), 32'h1);
    chk("to_err_once", 32'(bus.err_timeout), 32'h0);
    bus.last = 4'b0001;
    cyc();
    bus.req = 4'b0; bus.last = 4'b0;
    cyc();
    chk("to_drain", 32'(exp_q.size()), 32'h0);

    // ---------------- mid-packet reset ----------------
    do_reset();
    bus.cfg_we = 1'b1; bus.cfg_idx = 2'd1; bus.cfg_weight = 4'd5;
    cyc();
    bus.cfg_we = 1'b0;
    exp_q.push_back(1);
    bus.req = 4'b0010; bus.last = 4'b0; bus.out_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("mr_gnt_cleared", 32'(bus.gnt), 32'h0);
    chk("mr_no_done", 32'(bus.pkt_done), 32'h0);
    rst = 1'b0;
    exp_q.push_back(0);
    bus.req = 4'b0011; bus.last = 4'b0011;
    cyc();
    chk("mr_first_gnt", 32'(bus.gnt), 32'h1);
    cyc();
    chk("mr_pkt_done", 32'(bus.pkt_done), 32'h1);
    bus.req = 4'b0;
    cyc();
    chk("mr_drain", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
